// File: rtl/layer_sequencer_pkg.sv
// Shared types and default widths for the layer sequencer: FSM state
// encoding, forward/backward pass encoding and the phase counter width.
package layer_sequencer_pkg;

    localparam int unsigned BITS_DEFAULT = 16;
    localparam int unsigned CNT_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_FWD_RUN   = 3'd2,
        ST_FWD_DRAIN = 3'd3,
        ST_BWD_RUN   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    typedef enum logic {
        PASS_FWD = 1'b0,
        PASS_BWD = 1'b1
    } pass_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Request/ack handshake and neuron-datapath phase signals between a
// layer controller (master) and the layer sequencer (slave).
interface layer_sequencer_if
    import layer_sequencer_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) ();

    logic            fwd_req;
    logic            bwd_req;
    logic            fwd_ack;
    logic            bwd_ack;
    logic            FP;
    logic            BP;
    logic [BITS-1:0] y_in;
    logic [BITS-1:0] y_out;
    logic            y_valid;
    logic            bwd_done;
    logic            busy;

    modport master (
        output fwd_req, bwd_req, y_in,
        input  fwd_ack, bwd_ack, FP, BP, y_out, y_valid, bwd_done, busy
    );

    modport slave (
        input  fwd_req, bwd_req, y_in,
        output fwd_ack, bwd_ack, FP, BP, y_out, y_valid, bwd_done, busy
    );

endinterface

// File: rtl/layer_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is forward, bit 1 is backward.
// The priority pointer moves past the winner only when the grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0: forward has priority on a tie, 1: backward has priority
    logic pri_r;
    logic [1:0] grant_s;

    // Grant selection: only a simultaneous request consults the pointer
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = pri_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Pointer update on accept: the type just served loses the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_r <= 1'b0;
        end else if (accept) begin
            pri_r <= grant_s[0];
        end else begin
            pri_r <= pri_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/layer_sequencer.sv
// Forward/backward phase sequencer for one neuron layer: arbitrates pass
// requests, drives clean FP/BP phase windows and captures the activation.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int N    = 2,
    parameter int BITS = BITS_DEFAULT,
    parameter int PIPE = 3
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] HALF_M1    = CNT_W'(N / 2 - 1);
    localparam logic [CNT_W-1:0] BWD_LAST   = CNT_W'(N / 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE - 1);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    pass_t             pass_r, pass_s;
    logic [1:0]        grant_s;
    logic              accept_s;
    logic              fwd_ack_s, bwd_ack_s;
    logic              drain_last_s;
    logic              fp_r, bp_r, busy_r, y_valid_r, bwd_done_r;
    logic [BITS-1:0]   y_out_r;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.bwd_req, bus.fwd_req}),
        .accept (accept_s),
        .grant  (grant_s)
    );

    // Next-state, phase counter and the accept handshake
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pass_s    = pass_r;
        accept_s  = 1'b0;
        fwd_ack_s = 1'b0;
        bwd_ack_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                // acks are held off while reset is asserted so nothing is accepted then lost
                if (!rst && grant_s[0]) begin
                    fwd_ack_s = 1'b1;
                    accept_s  = 1'b1;
                    pass_s    = PASS_FWD;
                    state_s   = ST_GAP;
                end else if (!rst && grant_s[1]) begin
                    bwd_ack_s = 1'b1;
                    accept_s  = 1'b1;
                    pass_s    = PASS_BWD;
                    state_s   = ST_GAP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                cnt_s = '0;
                if (pass_r == PASS_FWD) begin
                    state_s = ST_FWD_RUN;
                end else begin
                    state_s = ST_BWD_RUN;
                end
            end
            ST_FWD_RUN: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s   = '0;
                    state_s = ST_FWD_DRAIN;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_FWD_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    cnt_s   = '0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BWD_RUN: begin
                if (cnt_r == BWD_LAST) begin
                    cnt_s   = '0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
            default: begin
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign drain_last_s = (state_r == ST_FWD_DRAIN) && (cnt_r == DRAIN_LAST);

    // State register plus outputs decoded from the next state so they are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            pass_r     <= PASS_FWD;
            fp_r       <= 1'b0;
            bp_r       <= 1'b0;
            busy_r     <= 1'b0;
            y_valid_r  <= 1'b0;
            bwd_done_r <= 1'b0;
            y_out_r    <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pass_r     <= pass_s;
            fp_r       <= (state_s == ST_FWD_RUN) || (state_s == ST_FWD_DRAIN);
            bp_r       <= (state_s == ST_BWD_RUN);
            busy_r     <= (state_s != ST_IDLE);
            y_valid_r  <= drain_last_s;
            // registered one cycle ahead so the pulse lands in the final BWD_RUN cycle
            bwd_done_r <= (state_r == ST_BWD_RUN) && (cnt_r == HALF_M1);
            if (drain_last_s) begin
                y_out_r <= bus.y_in;
            end else begin
                y_out_r <= y_out_r;
            end
        end
    end

    assign bus.fwd_ack  = fwd_ack_s;
    assign bus.bwd_ack  = bwd_ack_s;
    assign bus.FP       = fp_r;
    assign bus.BP       = bp_r;
    assign bus.busy     = busy_r;
    assign bus.y_valid  = y_valid_r;
    assign bus.bwd_done = bwd_done_r;
    assign bus.y_out    = y_out_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: an N=2 and an N=4 sequencer share one stimulus stream and
// are each checked against hand-derived cycle timelines.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd_req = 1'b0;
    logic        bwd_req = 1'b0;
    logic [15:0] y_in = 16'h0000;
    int          n_vec = 0;
    int          n_err = 0;

    layer_sequencer_if #(.BITS(16)) if2 ();
    layer_sequencer_if #(.BITS(16)) if4 ();

    assign if2.fwd_req = fwd_req;
    assign if2.bwd_req = bwd_req;
    assign if2.y_in    = y_in;
    assign if4.fwd_req = fwd_req;
    assign if4.bwd_req = bwd_req;
    assign if4.y_in    = y_in;

    layer_sequencer #(.N(2), .BITS(16), .PIPE(3)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    layer_sequencer #(.N(4), .BITS(16), .PIPE(3)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Enter the next cycle just after its rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit idle_seen;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_fp", if2.FP, 1'b0);
        chk("rst_bp", if2.BP, 1'b0);
        chk("rst_busy", if2.busy, 1'b0);
        chk("rst_yout", if2.y_out, 16'h0000);
        chk("rst_yvalid", if2.y_valid, 1'b0);
        chk("rst_bwddone", if4.bwd_done, 1'b0);

        // Forward pass: N=2 FP 2..5, y_valid 6; N=4 FP 2..6, y_valid 7
        for (int c = 0; c <= 9; c++) begin
            tick();
            rst     = 1'b0;
            fwd_req = (c == 0);
            y_in    = (c < 5) ? 16'h7777 : ((c == 5) ? 16'h0180 : 16'h1234);
            @(negedge clk);
            chk($sformatf("f2_ack@%0d", c), if2.fwd_ack, (c == 0));
            chk($sformatf("f4_ack@%0d", c), if4.fwd_ack, (c == 0));
            chk($sformatf("f2_fp@%0d", c), if2.FP, (c >= 2 && c <= 5));
            chk($sformatf("f4_fp@%0d", c), if4.FP, (c >= 2 && c <= 6));
            chk($sformatf("f2_yv@%0d", c), if2.y_valid, (c == 6));
            chk($sformatf("f4_yv@%0d", c), if4.y_valid, (c == 7));
            chk($sformatf("f2_busy@%0d", c), if2.busy, (c >= 1 && c <= 6));
            chk($sformatf("f_bp@%0d", c), {if2.BP, if4.BP}, 2'b00);
            if (c == 6) chk("f2_yout", if2.y_out, 16'h0180);
            if (c == 7) chk("f4_yout", if4.y_out, 16'h1234);
        end

        // Backward pass: N=2 BP 2..3 done 3; N=4 BP 2..4 done 4; y_out untouched
        for (int c = 0; c <= 6; c++) begin
            tick();
            bwd_req = (c == 0);
            y_in    = 16'h5555;
            @(negedge clk);
            chk($sformatf("b2_ack@%0d", c), if2.bwd_ack, (c == 0));
            chk($sformatf("b4_ack@%0d", c), if4.bwd_ack, (c == 0));
            chk($sformatf("b2_bp@%0d", c), if2.BP, (c >= 2 && c <= 3));
            chk($sformatf("b4_bp@%0d", c), if4.BP, (c >= 2 && c <= 4));
            chk($sformatf("b2_done@%0d", c), if2.bwd_done, (c == 3));
            chk($sformatf("b4_done@%0d", c), if4.bwd_done, (c == 4));
            chk($sformatf("b_fp@%0d", c), {if2.FP, if4.FP}, 2'b00);
            chk($sformatf("b_yv@%0d", c), {if2.y_valid, if4.y_valid}, 2'b00);
        end
        chk("b2_yout_kept", if2.y_out, 16'h0180);
        chk("b4_yout_kept", if4.y_out, 16'h1234);

        // Both requests held through reset: F@0, B@7, F@12, B@19, F@24 for N=2
        tick();
        rst     = 1'b1;
        fwd_req = 1'b1;
        bwd_req = 1'b1;
        tick();
        @(negedge clk);
        chk("rr_ack_in_rst", {if2.fwd_ack, if2.bwd_ack}, 2'b00);
        begin
            logic pfp2 = 1'b0, pbp2 = 1'b0, pfp4 = 1'b0, pbp4 = 1'b0;
            for (int c = 0; c <= 25; c++) begin
                tick();
                rst = 1'b0;
                @(negedge clk);
                chk($sformatf("rr_fack@%0d", c), if2.fwd_ack, (c == 0 || c == 12 || c == 24));
                chk($sformatf("rr_back@%0d", c), if2.bwd_ack, (c == 7 || c == 19));
                chk($sformatf("rr_ovl2@%0d", c), if2.FP & if2.BP, 1'b0);
                chk($sformatf("rr_ovl4@%0d", c), if4.FP & if4.BP, 1'b0);
                chk($sformatf("rr_gap2@%0d", c), (pfp2 & if2.BP) | (pbp2 & if2.FP), 1'b0);
                chk($sformatf("rr_gap4@%0d", c), (pfp4 & if4.BP) | (pbp4 & if4.FP), 1'b0);
                pfp2 = if2.FP;
                pbp2 = if2.BP;
                pfp4 = if4.FP;
                pbp4 = if4.BP;
            end
        end

        // Drop requests and wait (bounded) for both sequencers to settle
        tick();
        fwd_req   = 1'b0;
        bwd_req   = 1'b0;
        idle_seen = 1'b0;
        for (int w = 0; w < 40 && !idle_seen; w++) begin
            tick();
            @(negedge clk);
            idle_seen = !if2.busy && !if4.busy;
        end
        chk("idle_wait", idle_seen, 1'b1);

        // Reset during FWD_DRAIN: rst high in cycle 4, edge at cycle 5 clears all
        for (int c = 0; c <= 8; c++) begin
            tick();
            fwd_req = (c == 0);
            rst     = (c == 4);
            @(negedge clk);
            if (c == 0) chk("rd_yout_before", if2.y_out, 16'h5555);
            chk($sformatf("rd_fp2@%0d", c), if2.FP, (c >= 2 && c <= 4));
            chk($sformatf("rd_fp4@%0d", c), if4.FP, (c >= 2 && c <= 4));
            chk($sformatf("rd_yv@%0d", c), {if2.y_valid, if4.y_valid}, 2'b00);
            if (c >= 5) begin
                chk($sformatf("rd_busy@%0d", c), {if2.busy, if4.busy}, 2'b00);
                chk($sformatf("rd_yout2@%0d", c), if2.y_out, 16'h0000);
                chk($sformatf("rd_yout4@%0d", c), if4.y_out, 16'h0000);
            end
        end

        // fwd_req pulsed during BWD_RUN and dropped before DONE is never acked
        for (int c = 0; c <= 8; c++) begin
            tick();
            bwd_req = (c == 0);
            fwd_req = (c == 2);
            @(negedge clk);
            chk($sformatf("dp_fack@%0d", c), {if2.fwd_ack, if4.fwd_ack}, 2'b00);
            chk($sformatf("dp_fp@%0d", c), {if2.FP, if4.FP}, 2'b00);
            chk($sformatf("dp_done2@%0d", c), if2.bwd_done, (c == 3));
            chk($sformatf("dp_done4@%0d", c), if4.bwd_done, (c == 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
